// File: rtl/cordic_engine_if.sv
// FIFO-side signal bundle for cordic_engine: show-ahead angle FIFO read port and cos/sin FIFO write port.
// The engine is the master: it decides when to pop angles and push results.
interface cordic_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  out_full;
    logic                  out_wr_en;
    logic [DATA_WIDTH-1:0] cos_din;
    logic [DATA_WIDTH-1:0] sin_din;

    modport master (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, cos_din, sin_din
    );

    modport slave (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, cos_din, sin_din
    );
endinterface

// File: rtl/cordic_engine.sv
// Iterative rotation-mode CORDIC: pops one Q14 angle, runs NUM_ITER shift-add rotations,
// pushes cos/sin. One angle in flight; quadrant fold around +-PI/2 keeps the core in its convergence range.
module cordic_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 14,
    parameter int NUM_ITER   = 16
) (
    input  logic            clk,
    input  logic            reset,
    cordic_engine_if.master fifo
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, WRITE} state_t;
    typedef logic signed [DATA_WIDTH-1:0] word_t;

    localparam word_t      K       = word_t'(9949);
    localparam word_t      HALF_PI = word_t'(25736);
    localparam word_t      PI      = word_t'(51472);
    localparam logic [4:0] LAST    = 5'(NUM_ITER - 1);

    // Constants and atan table are Q14-only; refuse any other build.
    if (FRAC_BITS != 14 || NUM_ITER < 1 || NUM_ITER > 16) begin : g_bad_cfg
        $error("cordic_engine: unsupported FRAC_BITS/NUM_ITER");
    end

    function automatic word_t atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = word_t'(12868);
            5'd1:    atan_lut = word_t'(7596);
            5'd2:    atan_lut = word_t'(4014);
            5'd3:    atan_lut = word_t'(2037);
            5'd4:    atan_lut = word_t'(1023);
            5'd5:    atan_lut = word_t'(512);
            5'd6:    atan_lut = word_t'(256);
            5'd7:    atan_lut = word_t'(128);
            5'd8:    atan_lut = word_t'(64);
            5'd9:    atan_lut = word_t'(32);
            5'd10:   atan_lut = word_t'(16);
            5'd11:   atan_lut = word_t'(8);
            5'd12:   atan_lut = word_t'(4);
            5'd13:   atan_lut = word_t'(2);
            5'd14:   atan_lut = word_t'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    state_t     state_q, state_d;
    word_t      theta_q, theta_d;
    word_t      x_q, x_d, y_q, y_d, z_q, z_d;
    word_t      cos_q, cos_d, sin_q, sin_d;
    logic       neg_q, neg_d;
    logic [4:0] iter_q, iter_d;

    word_t      x_sh, y_sh, x_n, y_n, z_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            theta_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            neg_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            theta_q <= theta_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            neg_q   <= neg_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        theta_d        = theta_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        cos_d          = cos_q;
        sin_d          = sin_q;
        neg_d          = neg_q;
        iter_d         = iter_q;
        fifo.in_rd_en  = 1'b0;
        fifo.out_wr_en = 1'b0;

        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        // d = +1 when z >= 0, i.e. sign bit clear
        if (z_q[DATA_WIDTH-1]) begin
            x_n = x_q + y_sh;
            y_n = y_q - x_sh;
            z_n = z_q + atan_lut(iter_q);
        end else begin
            x_n = x_q - y_sh;
            y_n = y_q + x_sh;
            z_n = z_q - atan_lut(iter_q);
        end

        case (state_q)
            IDLE: begin
                // Gated by reset so no pop is requested while the core is held in reset.
                if (!fifo.in_empty && reset) begin
                    fifo.in_rd_en = 1'b1;
                    theta_d       = word_t'(fifo.in_dout);
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                if (theta_q > HALF_PI) begin
                    z_d   = theta_q - PI;
                    neg_d = 1'b1;
                end else if (theta_q < -HALF_PI) begin
                    z_d   = theta_q + PI;
                    neg_d = 1'b1;
                end else begin
                    z_d   = theta_q;
                    neg_d = 1'b0;
                end
                x_d     = K;
                y_d     = '0;
                iter_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d    = x_n;
                y_d    = y_n;
                z_d    = z_n;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST) begin
                    cos_d   = neg_q ? -x_n : x_n;
                    sin_d   = neg_q ? -y_n : y_n;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!fifo.out_full) begin
                    fifo.out_wr_en = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo.cos_din = cos_q;
    assign fifo.sin_din = sin_q;
endmodule
